core_harness_ctrl: RTL and testbench
====================================

# core_harness_ctrl

Synthesizable run-and-check controller for the multicycle RV64 core (`control_top`). It replaces the free-running, `$monitor`-only bench flow.
- Sequences core reset and counts cycles and retired fetches.
- Detects end of program: a halt instruction, a self-loop, or a timeout.
- Compares a programmable table of expected register values against the register file through a read port.
- Reports a sticky pass/fail result, usable in simulation and on-chip.

## Interface
Parameters:
- `NUM_CHECKS`, 8: entries in the expected-value table (1..32).
- `TIMEOUT_CYCLES`, 4096: core cycles in RUN before forced fail.
- `HOLD_CYCLES`, 2: cycles `core_reset` stays high after `reset` deasserts (≥1).
- `HALT_INSTR`, 32'h0000_0073: instruction word that ends the run (ecall).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `core_reset`  out  1  reset to `control_top`.
- `fetch_valid`  in  1  one-cycle strobe when the instruction register loads.
- `fetch_instr`  in  32  instruction word loaded with `fetch_valid`.
- `fetch_pc`  in  64  PC of that instruction.
- `reg_rd_addr`  out  5  register-file scan address.
- `reg_rd_data`  in  64  register-file data; 1-cycle read latency.
- `cfg_we`  in  1  write one table entry; accepted in any state.
- `cfg_idx`  in  $clog2(NUM_CHECKS)  entry index.
- `cfg_addr`  in  5  register to check.
- `cfg_data`  in  64  expected value.
- `cfg_en`  in  1  entry valid bit written with the entry.
- `done`  out  1  sticky; run finished.
- `pass`  out  1  sticky; valid when `done`.
- `fail_idx`  out  $clog2(NUM_CHECKS)  first failing entry.
- `timed_out`  out  1  sticky.
- `cycle_count`  out  32  cycles spent in RUN.
- `instr_count`  out  32  `fetch_valid` pulses in RUN.

## Operation
FSM states are HOLD, RUN, CHK_ADDR, CHK_CMP and DONE.

- **HOLD**
  - Entered on `reset`.
  - `core_reset`=1; hold counter counts up.
  - Moves to RUN after HOLD_CYCLES cycles with `reset` low.
- **RUN**
  - `core_reset`=0. `cycle_count` +1 every cycle; `instr_count` +1 per `fetch_valid`.
  - A halt is a `fetch_valid` where either `fetch_instr`==HALT_INSTR or `fetch_pc` equals the PC of the previous fetch (self-loop, e.g. `beq x0,x0,0`).
  - The previous-fetch PC register resets to all-ones.
  - Halt → CHK_ADDR with check index 0.
  - If `cycle_count` reaches TIMEOUT_CYCLES-1 with no halt, the next state is DONE with `timed_out`=1 and `pass`=0.
  - A halt and a timeout in the same cycle: halt wins.
- **CHK_ADDR**
  - `core_reset`=1, which freezes the core; regfile state is kept by the core's design.
  - Drives `reg_rd_addr` from the entry. Entries with valid=0 are skipped with no cycle cost, checked combinationally.
  - No valid entries left → DONE with `pass`=1.
- **CHK_CMP**
  - Compares `reg_rd_data` with the expected value.
  - Mismatch → DONE, `pass`=0, `fail_idx`=index.
  - Match → index+1, back to CHK_ADDR; past the last entry → DONE, `pass`=1.
- **DONE**
  - `core_reset`=1. All result outputs hold until `reset`.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- A `cfg_we` during CHK_* changes results from the next comparison on; software must configure before RUN.

## Timing
- Reset values:
  - `core_reset`=1; `done`=0, `pass`=0, `timed_out`=0.
  - `fail_idx`=0, `reg_rd_addr`=0, counters=0.
  - Table entries all valid=0, so an unconfigured run passes on halt.
- HOLD to RUN: `core_reset` falls exactly HOLD_CYCLES rising edges after `reset` deasserts.
- Halt latency: the state is CHK_ADDR one cycle after the halt fetch strobe, and `core_reset` rises the same edge.
- Checks cost 2 cycles per valid entry.
- `done` rises 1 cycle after the last CHK_CMP, or 1 cycle after the timeout cycle.
- Asserting `reset` mid-run or mid-check: immediate return to HOLD, all outputs to reset values, table cleared.

## Structure
- `harness_pkg`: state enum, `HALT_ECALL`=32'h0000_0073, `HALT_SELF_BEQ`=32'h0000_0063, `check_entry_t` struct {en, addr[4:0], data[63:0]}.
- One sub-module, `expect_table`:
  - NUM_CHECKS-entry register array, one write port (cfg) and one combinational read port.
  - Also provides the next-valid-index search from a start index.
- Top module holds the FSM, counters and halt detect.

## Test plan
- Reset sequence, HOLD_CYCLES=2: `reset` 1→0 at edge 0 → `core_reset` falls after edge 2; all outputs zero before that.
- Type-R program: x1=160, x2=2, x3=5, x4=0 expected, halt via ecall after 12 fetches.
  - Response: `done`=1, `pass`=1, `instr_count`=12, `done` 1+4×2+1 cycles after the halt strobe.
- Same program with entry 2 expecting x3=6 → `pass`=0, `fail_idx`=2; entries 3+ not read (`reg_rd_addr` never 4).
- Self-loop: fetch PC 0x40 twice in a row → halt on the second strobe; a single fetch at 0x40 after 0x3C does not halt.
- Timeout, TIMEOUT_CYCLES=100, no halt → `timed_out`=1, `pass`=0, `cycle_count`=99, `done` on cycle 101 of RUN.
- `reset` asserted during CHK_CMP → immediate HOLD, `done`=0, table cleared; rerun with no config then passes at halt.

Source files
------------

// File: rtl/core_harness_ctrl_pkg.sv
// core_harness_ctrl_pkg: shared FSM state type, halt encodings, table entry type and counter helpers
package core_harness_ctrl_pkg;
    typedef enum logic [2:0] {HOLD, RUN, CHK_ADDR, CHK_CMP, DONE} state_t;
    localparam logic [31:0] HALT_ECALL    = 32'h0000_0073;
    localparam logic [31:0] HALT_SELF_BEQ = 32'h0000_0063;
    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } check_entry_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/core_harness_ctrl_if.sv
// core_harness_ctrl_if: core fetch/regfile, table config and result signals of the harness
//   master: the harness controller; slave: the core / host side
interface core_harness_ctrl_if #(parameter int NUM_CHECKS = 8);
    import core_harness_ctrl_pkg::*;
    localparam int IW = idx_w(NUM_CHECKS);
    logic          core_reset;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic [63:0]   fetch_pc;
    logic [4:0]    reg_rd_addr;
    logic [63:0]   reg_rd_data;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [4:0]    cfg_addr;
    logic [63:0]   cfg_data;
    logic          cfg_en;
    logic          done;
    logic          pass;
    logic [IW-1:0] fail_idx;
    logic          timed_out;
    logic [31:0]   cycle_count;
    logic [31:0]   instr_count;
    modport master (
        output core_reset, reg_rd_addr, done, pass, fail_idx, timed_out, cycle_count, instr_count,
        input  fetch_valid, fetch_instr, fetch_pc, reg_rd_data, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_en
    );
    modport slave (
        input  core_reset, reg_rd_addr, done, pass, fail_idx, timed_out, cycle_count, instr_count,
        output fetch_valid, fetch_instr, fetch_pc, reg_rd_data, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_en
    );
endinterface

// File: rtl/core_harness_ctrl_expect_table.sv
// core_harness_ctrl_expect_table: expected-register table with one write port, one read port and next-valid search
//   we_i/wr_idx_i/wr_entry_i: entry write; rd_idx_i -> rd_addr_o/rd_data_o: combinational read
//   start_i -> nxt_o/found_o: lowest valid entry index >= start_i
module core_harness_ctrl_expect_table
    import core_harness_ctrl_pkg::*;
#(
    parameter int  NUM_CHECKS = 8,
    localparam int IW         = idx_w(NUM_CHECKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [IW-1:0] wr_idx_i,
    input  check_entry_t  wr_entry_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [4:0]    rd_addr_o,
    output logic [63:0]   rd_data_o,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] nxt_o,
    output logic          found_o
);
    check_entry_t tbl_q [NUM_CHECKS];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl_q[i] <= '0;
        end else if (we_i && int'(wr_idx_i) < NUM_CHECKS) begin
            tbl_q[wr_idx_i] <= wr_entry_i;
        end
    end
    assign rd_addr_o = tbl_q[rd_idx_i].addr;
    assign rd_data_o = tbl_q[rd_idx_i].data;
    // Scanning downwards leaves the lowest qualifying index as the final winner.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (tbl_q[i].en && i >= int'(start_i)) begin
                nxt_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_harness_ctrl.sv
// core_harness_ctrl: run-and-check controller sequencing core reset, detecting end of program and checking registers
//   clk/reset: clock and async active-high reset; bus (master): core fetch/regfile, table config, sticky results
module core_harness_ctrl
    import core_harness_ctrl_pkg::*;
#(
    parameter int          NUM_CHECKS     = 8,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          HOLD_CYCLES    = 2,
    parameter logic [31:0] HALT_INSTR     = HALT_ECALL
) (
    input logic                 clk,
    input logic                 reset,
    core_harness_ctrl_if.master bus
);
    localparam int            IW   = idx_w(NUM_CHECKS);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHECKS - 1);
    state_t        state_q, state_d;
    logic [31:0]   hold_q, hold_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] fail_q, fail_d;
    logic [4:0]    addr_q, addr_d;
    logic [63:0]   prev_pc_q, prev_pc_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   ins_q, ins_d;
    logic          pass_q, pass_d;
    logic          to_q, to_d;
    logic          core_rst_q;
    logic          halt, timeout, found, mism;
    logic [IW-1:0] nxt, rd_idx;
    logic [4:0]    tbl_addr;
    logic [63:0]   tbl_data;
    check_entry_t  wr_entry;
    assign wr_entry = '{en: bus.cfg_en, addr: bus.cfg_addr, data: bus.cfg_data};
    // CHK_ADDR reads the entry the search lands on; CHK_CMP reads the entry being compared.
    assign rd_idx  = (state_q == CHK_ADDR) ? nxt : idx_q;
    assign halt    = bus.fetch_valid && (bus.fetch_instr == HALT_INSTR || bus.fetch_pc == prev_pc_q);
    assign timeout = cyc_q == 32'(TIMEOUT_CYCLES - 1);
    assign mism    = bus.reg_rd_data != tbl_data;
    core_harness_ctrl_expect_table #(.NUM_CHECKS(NUM_CHECKS)) u_tbl (
        .clk        (clk),
        .reset      (reset),
        .we_i       (bus.cfg_we),
        .wr_idx_i   (bus.cfg_idx),
        .wr_entry_i (wr_entry),
        .rd_idx_i   (rd_idx),
        .rd_addr_o  (tbl_addr),
        .rd_data_o  (tbl_data),
        .start_i    (idx_q),
        .nxt_o      (nxt),
        .found_o    (found)
    );
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        fail_d    = fail_q;
        addr_d    = addr_q;
        prev_pc_d = prev_pc_q;
        cyc_d     = cyc_q;
        ins_d     = ins_q;
        pass_d    = pass_q;
        to_d      = to_q;
        case (state_q)
            HOLD: begin
                hold_d  = hold_q + 32'd1;
                state_d = (hold_q == 32'(HOLD_CYCLES - 1)) ? RUN : HOLD;
            end
            RUN: begin
                state_d   = halt ? CHK_ADDR : (timeout ? DONE : RUN);
                idx_d     = '0;
                to_d      = !halt && timeout;
                // The timeout cycle is left uncounted so cycle_count reports the limit that fired.
                cyc_d     = sat_inc(cyc_q, halt || !timeout);
                ins_d     = sat_inc(ins_q, bus.fetch_valid);
                prev_pc_d = bus.fetch_valid ? bus.fetch_pc : prev_pc_q;
            end
            CHK_ADDR: begin
                state_d = found ? CHK_CMP : DONE;
                pass_d  = !found;
                idx_d   = nxt;
                addr_d  = found ? tbl_addr : addr_q;
            end
            CHK_CMP: begin
                state_d = (mism || idx_q == LAST) ? DONE : CHK_ADDR;
                pass_d  = !mism && idx_q == LAST;
                fail_d  = mism ? idx_q : fail_q;
                idx_d   = idx_q + IW'(1);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HOLD;
            hold_q     <= '0;
            idx_q      <= '0;
            fail_q     <= '0;
            addr_q     <= '0;
            prev_pc_q  <= '1;
            cyc_q      <= '0;
            ins_q      <= '0;
            pass_q     <= 1'b0;
            to_q       <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            fail_q     <= fail_d;
            addr_q     <= addr_d;
            prev_pc_q  <= prev_pc_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
            pass_q     <= pass_d;
            to_q       <= to_d;
            core_rst_q <= state_d != RUN;
        end
    end
    assign bus.core_reset  = core_rst_q;
    assign bus.reg_rd_addr = addr_d;
    assign bus.done        = state_q == DONE;
    assign bus.pass        = pass_q;
    assign bus.fail_idx    = fail_q;
    assign bus.timed_out   = to_q;
    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
endmodule

// File: tb/tb_core_harness_ctrl.sv
// tb_core_harness_ctrl: directed table-driven bench for the run-and-check harness controller
module tb_core_harness_ctrl;
    import core_harness_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    core_harness_ctrl_if #(.NUM_CHECKS(8)) bus();
    core_harness_ctrl #(.NUM_CHECKS(8), .TIMEOUT_CYCLES(100), .HOLD_CYCLES(2), .HALT_INSTR(HALT_ECALL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );
    logic [63:0] regs [32];
    int cnt4 = 0;
    always @(posedge clk) bus.reg_rd_data <= regs[bus.reg_rd_addr];
    always @(negedge clk) if (bus.reg_rd_addr == 5'd4) cnt4 <= cnt4 + 1;
    typedef struct {
        string       name;
        logic [7:0]  en;
        logic [4:0]  addr [8];
        logic [63:0] data [8];
        int          nfetch;
        logic [31:0] body;
        logic        selfloop;
        logic        exp_pass;
        logic [2:0]  exp_fail;
        int          exp_lat;
        logic        exp_saw4;
    } vec_t;
    vec_t v [7];
    int checks = 0;
    int errors = 0;
    int n;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic do_reset;
        reset = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.cfg_we = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        tick;
    endtask
    task automatic cfg(input int i, input logic en, input logic [4:0] a, input logic [63:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 3'(i);
        bus.cfg_en = en;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick;
        bus.cfg_we = 1'b0;
    endtask
    task automatic fetch(input logic [63:0] pc, input logic [31:0] ins);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc = pc;
        bus.fetch_instr = ins;
        tick;
        bus.fetch_valid = 1'b0;
    endtask
    task automatic wait_done(output int cnt);
        cnt = 1;
        while (!bus.done && cnt < 200) begin
            tick;
            cnt++;
        end
    endtask
    task automatic run_vec(input vec_t x);
        logic [63:0] base;
        int c0, lat;
        do_reset;
        for (int i = 0; i < 8; i++) cfg(i, x.en[i], x.addr[i], x.data[i]);
        c0 = cnt4;
        base = x.selfloop ? 64'h38 : 64'h0;
        for (int i = 0; i < x.nfetch - 1; i++) begin
            fetch(base + 64'(4 * i), x.body);
            tick;
            tick;
        end
        chk({x.name, " no_early_halt"}, bus.core_reset, 0);
        fetch(base + 64'(4 * (x.selfloop ? x.nfetch - 2 : x.nfetch - 1)), x.selfloop ? x.body : HALT_ECALL);
        chk({x.name, " halt_core_reset"}, bus.core_reset, 1);
        wait_done(lat);
        chk({x.name, " done_latency"}, 64'(lat), 64'(x.exp_lat));
        chk({x.name, " pass"}, bus.pass, x.exp_pass);
        chk({x.name, " fail_idx"}, bus.fail_idx, x.exp_fail);
        chk({x.name, " instr_count"}, bus.instr_count, 64'(x.nfetch));
        chk({x.name, " timed_out"}, bus.timed_out, 0);
        chk({x.name, " read_x4"}, cnt4 != c0, x.exp_saw4);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        regs[1] = 64'd160;
        regs[2] = 64'd2;
        regs[3] = 64'd5;
        regs[4] = 64'd0;
        v[0].name = "typeR_pass";
        v[0].en = 8'h0F;
        v[0].addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
        v[0].data = '{64'd160, 64'd2, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        v[0].nfetch = 12;
        v[0].body = 32'h0000_0013;
        v[0].selfloop = 1'b0;
        v[0].exp_pass = 1'b1;
        v[0].exp_fail = 3'd0;
        v[0].exp_lat = 10;
        v[0].exp_saw4 = 1'b1;
        v[1] = v[0];
        v[1].name = "typeR_fail";
        v[1].data[2] = 64'd6;
        v[1].exp_pass = 1'b0;
        v[1].exp_fail = 3'd2;
        v[1].exp_lat = 7;
        v[1].exp_saw4 = 1'b0;
        v[2] = v[0];
        v[2].name = "self_loop";
        v[2].nfetch = 4;
        v[2].body = HALT_SELF_BEQ;
        v[2].selfloop = 1'b1;
        v[3] = v[0];
        v[3].name = "unconfigured";
        v[3].en = 8'h00;
        v[3].nfetch = 3;
        v[3].exp_lat = 2;
        v[3].exp_saw4 = 1'b0;
        v[4] = v[0];
        v[4].name = "sparse";
        v[4].en = 8'b0010_0001;
        v[4].addr[5] = 5'd4;
        v[4].data[5] = 64'd0;
        v[4].exp_lat = 6;
        v[5] = v[0];
        v[5].name = "last_only";
        v[5].en = 8'h80;
        v[5].addr[7] = 5'd2;
        v[5].data[7] = 64'd2;
        v[5].exp_lat = 3;
        v[5].exp_saw4 = 1'b0;
        v[6] = v[5];
        v[6].name = "last_fail";
        v[6].data[7] = 64'd3;
        v[6].exp_pass = 1'b0;
        v[6].exp_fail = 3'd7;
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = '0;
        bus.fetch_pc = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.cfg_en = 1'b0;
        #2 reset = 1'b1;
        tick;
        chk("rst core_reset", bus.core_reset, 1);
        chk("rst done", bus.done, 0);
        chk("rst pass", bus.pass, 0);
        chk("rst timed_out", bus.timed_out, 0);
        chk("rst fail_idx", bus.fail_idx, 0);
        chk("rst reg_rd_addr", bus.reg_rd_addr, 0);
        chk("rst cycle_count", bus.cycle_count, 0);
        chk("rst instr_count", bus.instr_count, 0);
        reset = 1'b0;
        tick;
        chk("hold edge1 core_reset", bus.core_reset, 1);
        tick;
        chk("hold edge2 core_reset", bus.core_reset, 0);
        for (int k = 0; k < 7; k++) run_vec(v[k]);
        do_reset;
        n = 0;
        while (!bus.done && n < 300) begin
            tick;
            n++;
        end
        chk("timeout latency", 64'(n), 64'd100);
        chk("timeout timed_out", bus.timed_out, 1);
        chk("timeout pass", bus.pass, 0);
        chk("timeout cycle_count", bus.cycle_count, 99);
        chk("timeout instr_count", bus.instr_count, 0);
        chk("timeout core_reset", bus.core_reset, 1);
        do_reset;
        repeat (99) tick;
        chk("tie cycle_count", bus.cycle_count, 99);
        fetch(64'h0, HALT_ECALL);
        chk("tie timed_out", bus.timed_out, 0);
        chk("tie core_reset", bus.core_reset, 1);
        wait_done(n);
        chk("tie done_latency", 64'(n), 64'd2);
        chk("tie pass", bus.pass, 1);
        do_reset;
        for (int i = 0; i < 8; i++) cfg(i, v[1].en[i], v[1].addr[i], v[1].data[i]);
        fetch(64'h0, HALT_ECALL);
        tick;
        reset = 1'b1;
        #1;
        chk("midrst core_reset", bus.core_reset, 1);
        chk("midrst done", bus.done, 0);
        chk("midrst reg_rd_addr", bus.reg_rd_addr, 0);
        chk("midrst cycle_count", bus.cycle_count, 0);
        chk("midrst instr_count", bus.instr_count, 0);
        tick;
        reset = 1'b0;
        tick;
        tick;
        fetch(64'h0, HALT_ECALL);
        wait_done(n);
        chk("rerun done_latency", 64'(n), 64'd2);
        chk("rerun pass", bus.pass, 1);
        chk("rerun done", bus.done, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
